// File: rtl/sentinel_auth_sequencer.sv
// -----------------------------------------------------------------------------
// sentinel_auth_sequencer
//
// Four-byte authorization sequencer. Each attempt collects exactly four key
// bytes and compares them against KEY without aborting early on a mismatch. A
// correct attempt opens the lock (VERIFIED) until a clear request arrives. An
// attempt that is wrong or times out counts as a failure, and MAX_FAIL
// failures force a timed LOCKOUT. While ena is low, all state holds.
//
// Parameters
//   KEY            four-byte sequence; byte 0 = KEY[31:24], byte 3 = KEY[7:0]
//   MAX_FAIL       failed attempts that trigger lockout (1-7)
//   LOCKOUT_CYCLES lockout duration in enabled cycles (1-65535)
//   BYTE_TIMEOUT   max enabled cycles between bytes of one attempt (1-255)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ena        global enable; low freezes all state and outputs
//   key_byte   candidate key byte, qualified by key_valid
//   key_valid  single-cycle strobe for key_byte
//   clear      relock / abort request
//   status     seven-segment code: C7 locked, C1 verified, 8E lockout
//   verified   high only while VERIFIED
//   locked_out high only while LOCKOUT
//   fail_count failed attempts since last success or lockout expiry
// -----------------------------------------------------------------------------
module sentinel_auth_sequencer #(
    parameter logic [31:0] KEY            = 32'hB63A5CE1,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024,
    parameter int unsigned BYTE_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] key_byte,
    input  logic       key_valid,
    input  logic       clear,
    output logic [7:0] status,
    output logic       verified,
    output logic       locked_out,
    output logic [2:0] fail_count
);

    localparam logic [2:0]  MAX_FAIL_C  = 3'(MAX_FAIL);
    localparam logic [15:0] LOCK_LOAD   = 16'(LOCKOUT_CYCLES);
    localparam logic [7:0]  BYTE_LOAD   = 8'(BYTE_TIMEOUT);

    localparam logic [7:0]  ST_LOCKED   = 8'hC7;
    localparam logic [7:0]  ST_VERIFIED = 8'hC1;
    localparam logic [7:0]  ST_LOCKOUT  = 8'h8E;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_VERIFIED = 2'd2,
        S_LOCKOUT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;              // index of the next byte to compare
    logic        mismatch_q, mismatch_d;    // sticky: any byte of this attempt wrong
    logic [7:0]  byte_timer_q, byte_timer_d;
    logic [15:0] lock_timer_q, lock_timer_d;
    logic [2:0]  fail_q, fail_d;
    logic [7:0]  status_q, status_d;
    logic        verified_q, verified_d;
    logic        locked_out_q, locked_out_d;

    // Key byte expected at the current collection index.
    logic [7:0] expected_byte;
    always_comb begin
        case (idx_q)
            2'd0:    expected_byte = KEY[31:24];
            2'd1:    expected_byte = KEY[23:16];
            2'd2:    expected_byte = KEY[15:8];
            default: expected_byte = KEY[7:0];
        endcase
    end

    logic mismatch_now;
    assign mismatch_now = mismatch_q | (key_byte != expected_byte);

    logic       attempt_done;
    logic       attempt_bad;
    logic [2:0] fail_inc;

    always_comb begin
        // NOTE: every signal driven here gets a hold/default value first, so no
        // path through the branches below can leave one unassigned (no latches).
        state_d      = state_q;
        idx_d        = idx_q;
        mismatch_d   = mismatch_q;
        byte_timer_d = byte_timer_q;
        lock_timer_d = lock_timer_q;
        fail_d       = fail_q;
        attempt_done = 1'b0;
        attempt_bad  = 1'b0;
        fail_inc     = fail_q;

        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        // clear beats a simultaneous key_valid: byte is dropped
                        idx_d      = 2'd0;
                        mismatch_d = 1'b0;
                    end else if (key_valid) begin
                        state_d      = S_COLLECT;
                        idx_d        = 2'd1;
                        mismatch_d   = (key_byte != KEY[31:24]);
                        byte_timer_d = BYTE_LOAD;
                    end
                end

                S_COLLECT: begin
                    if (clear) begin
                        // abort without charging a failed attempt
                        state_d      = S_IDLE;
                        idx_d        = 2'd0;
                        mismatch_d   = 1'b0;
                        byte_timer_d = 8'd0;
                    end else if (key_valid) begin
                        // a byte arriving on the timeout cycle still counts
                        if (idx_q == 2'd3) begin
                            attempt_done = 1'b1;
                            attempt_bad  = mismatch_now;
                        end else begin
                            idx_d        = idx_q + 2'd1;
                            mismatch_d   = mismatch_now;
                            byte_timer_d = BYTE_LOAD;
                        end
                    end else if (byte_timer_q <= 8'd1) begin
                        attempt_done = 1'b1;
                        attempt_bad  = 1'b1;
                    end else begin
                        byte_timer_d = byte_timer_q - 8'd1;
                    end
                end

                S_VERIFIED: begin
                    if (clear) begin
                        state_d    = S_IDLE;
                        idx_d      = 2'd0;
                        mismatch_d = 1'b0;
                    end
                end

                S_LOCKOUT: begin
                    // key_valid and clear are deliberately ignored here
                    if (lock_timer_q <= 16'd1) begin
                        state_d      = S_IDLE;
                        lock_timer_d = 16'd0;
                        fail_d       = 3'd0;
                    end else begin
                        lock_timer_d = lock_timer_q - 16'd1;
                    end
                end

                default: state_d = S_IDLE;
            endcase

            if (attempt_done) begin
                idx_d        = 2'd0;
                mismatch_d   = 1'b0;
                byte_timer_d = 8'd0;
                if (!attempt_bad) begin
                    state_d = S_VERIFIED;
                    fail_d  = 3'd0;
                end else begin
                    fail_inc = (fail_q < MAX_FAIL_C) ? fail_q + 3'd1 : fail_q;
                    fail_d   = fail_inc;
                    if (fail_inc == MAX_FAIL_C) begin
                        state_d      = S_LOCKOUT;
                        lock_timer_d = LOCK_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        end

        // Outputs are registered from the next state so they change on the
        // same edge as the state register (verified appears one cycle after
        // the fourth byte is sampled).
        status_d     = ST_LOCKED;
        verified_d   = 1'b0;
        locked_out_d = 1'b0;
        case (state_d)
            S_VERIFIED: begin
                status_d   = ST_VERIFIED;
                verified_d = 1'b1;
            end
            S_LOCKOUT: begin
                status_d     = ST_LOCKOUT;
                locked_out_d = 1'b1;
            end
            default: status_d = ST_LOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            mismatch_q   <= 1'b0;
            byte_timer_q <= 8'd0;
            lock_timer_q <= 16'd0;
            fail_q       <= 3'd0;
            status_q     <= ST_LOCKED;
            verified_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            idx_q        <= idx_d;
            mismatch_q   <= mismatch_d;
            byte_timer_q <= byte_timer_d;
            lock_timer_q <= lock_timer_d;
            fail_q       <= fail_d;
            status_q     <= status_d;
            verified_q   <= verified_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign status     = status_q;
    assign verified   = verified_q;
    assign locked_out = locked_out_q;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_sentinel_auth_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sentinel_auth_sequencer
//
// Directed scenarios followed by a randomized run. A behavioural model keeps
// the bytes of the current attempt in a queue and judges a finished attempt by
// comparing the whole four-byte word against KEY; every cycle the DUT outputs
// are compared with what the model predicts.
// -----------------------------------------------------------------------------
module tb_sentinel_auth_sequencer;

    localparam logic [31:0] KEY            = 32'hB63A5CE1;
    localparam int          MAX_FAIL       = 3;
    localparam int          LOCKOUT_CYCLES = 1024;
    localparam int          BYTE_TIMEOUT   = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] key_byte = 8'h00;
    logic       key_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] status;
    logic       verified;
    logic       locked_out;
    logic [2:0] fail_count;

    sentinel_auth_sequencer #(
        .KEY            (KEY),
        .MAX_FAIL       (MAX_FAIL),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .BYTE_TIMEOUT   (BYTE_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .key_byte   (key_byte),
        .key_valid  (key_valid),
        .clear      (clear),
        .status     (status),
        .verified   (verified),
        .locked_out (locked_out),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    // mode: 0 = open for bytes, 1 = verified, 2 = lockout
    int         m_mode;
    logic [7:0] m_bytes[$];
    int         m_gap;
    int         m_fails;
    int         m_lock_left;

    function automatic logic [7:0] key_at(input int i);
        logic [31:0] k;
        k = KEY;
        return k[31-8*i -: 8];
    endfunction

    function automatic void model_reset();
        m_mode      = 0;
        m_bytes.delete();
        m_gap       = 0;
        m_fails     = 0;
        m_lock_left = 0;
    endfunction

    function automatic void model_fail();
        if (m_fails < MAX_FAIL) m_fails++;
        if (m_fails == MAX_FAIL) begin
            m_mode      = 2;
            m_lock_left = LOCKOUT_CYCLES;
        end
    endfunction

    function automatic void model_edge(input logic e, input logic kv,
                                       input logic [7:0] b, input logic c);
        logic [31:0] word;
        if (!e) return;
        case (m_mode)
            0: begin
                if (c) begin
                    m_bytes.delete();
                end else if (kv) begin
                    m_bytes.push_back(b);
                    m_gap = 0;
                    if (m_bytes.size() == 4) begin
                        word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                        m_bytes.delete();
                        if (word == KEY) begin
                            m_mode  = 1;
                            m_fails = 0;
                        end else begin
                            model_fail();
                        end
                    end
                end else if (m_bytes.size() > 0) begin
                    m_gap++;
                    if (m_gap == BYTE_TIMEOUT) begin
                        m_bytes.delete();
                        model_fail();
                    end
                end
            end
            1: if (c) m_mode = 0;
            default: begin
                m_lock_left--;
                if (m_lock_left == 0) begin
                    m_mode  = 0;
                    m_fails = 0;
                end
            end
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] es;
        es = (m_mode == 1) ? 8'hC1 : (m_mode == 2) ? 8'h8E : 8'hC7;
        check({tag, "/status"},     32'(status),     32'(es));
        check({tag, "/verified"},   32'(verified),   32'(m_mode == 1));
        check({tag, "/locked_out"}, 32'(locked_out), 32'(m_mode == 2));
        check({tag, "/fail_count"}, 32'(fail_count), 32'(m_fails));
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic cycle(input logic e, input logic kv, input logic [7:0] b,
                         input logic c, input string tag);
        ena       = e;
        key_valid = kv;
        key_byte  = b;
        clear     = c;
        @(posedge clk);
        model_edge(e, kv, b, c);
        #1;
        check_outputs(tag);
    endtask

    task automatic send4(input logic [31:0] w, input string tag);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, w[31-8*i -: 8], 1'b0, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, tag);
    endtask

    // Assert rst_n between edges, verify outputs drop without a clock edge,
    // hold through one rising edge, release after it.
    task automatic mid_clock_reset(input string tag);
        key_valid = 1'b0;
        clear     = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check(tag, 32'(status), 32'h0000_00C7);
        check_outputs(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();

        // Reset for five cycles.
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset/status", 32'(status), 32'h0000_00C7);
        check_outputs("reset");
        rst_n = 1'b1;

        // Correct sequence -> verified one cycle after the last byte; clear relocks.
        send4(KEY, "good_seq");
        check("good_seq/verified_now", 32'(verified), 32'd1);
        check("good_seq/status_c1", 32'(status), 32'h0000_00C1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1, "clear_verified");
        check("clear_verified/status_c7", 32'(status), 32'h0000_00C7);

        // Wrong second byte: still four bytes consumed, then one failure.
        send4(32'hB6005CE1, "bad_seq1");
        check("bad_seq1/fail1", 32'(fail_count), 32'd1);
        send4(32'hB6005CE1, "bad_seq2");
        send4(32'hB6005CE1, "bad_seq3");
        check("lockout/locked_out", 32'(locked_out), 32'd1);
        check("lockout/status_8e", 32'(status), 32'h0000_008E);

        // Correct sequence ignored in lockout; ena low stretches it by 10.
        send4(KEY, "lockout_key_ignored");
        check("lockout_key_ignored/verified0", 32'(verified), 32'd0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, "ena_low");
        idle(LOCKOUT_CYCLES - 4 - 1, "lockout_wait");
        check("lockout_last_cycle/locked_out", 32'(locked_out), 32'd1);
        idle(1, "lockout_expiry");
        check("lockout_expiry/locked_out0", 32'(locked_out), 32'd0);
        check("lockout_expiry/fail0", 32'(fail_count), 32'd0);

        // Inter-byte timeout after two bytes.
        cycle(1'b1, 1'b1, 8'hB6, 1'b0, "timeout_b0");
        cycle(1'b1, 1'b1, 8'h3A, 1'b0, "timeout_b1");
        idle(BYTE_TIMEOUT - 1, "timeout_wait");
        check("timeout_before/fail0", 32'(fail_count), 32'd0);
        idle(1, "timeout_hit");
        check("timeout_hit/fail1", 32'(fail_count), 32'd1);
        send4(KEY, "after_timeout_good");
        check("after_timeout_good/verified", 32'(verified), 32'd1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1, "clear2");

        // Fourth byte arriving on the timeout cycle is accepted.
        cycle(1'b1, 1'b1, 8'hB6, 1'b0, "race_b0");
        cycle(1'b1, 1'b1, 8'h3A, 1'b0, "race_b1");
        cycle(1'b1, 1'b1, 8'h5C, 1'b0, "race_b2");
        idle(BYTE_TIMEOUT - 1, "race_wait");
        cycle(1'b1, 1'b1, 8'hE1, 1'b0, "race_b3");
        check("race/verified", 32'(verified), 32'd1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1, "clear3");

        // Reset mid-attempt discards progress and the failure count.
        send4(32'h00000000, "pre_reset_fail");
        cycle(1'b1, 1'b1, 8'hB6, 1'b0, "rst_b0");
        cycle(1'b1, 1'b1, 8'h3A, 1'b0, "rst_b1");
        cycle(1'b1, 1'b1, 8'h5C, 1'b0, "rst_b2");
        mid_clock_reset("mid_attempt_reset");
        check("mid_attempt_reset/fail0", 32'(fail_count), 32'd0);
        cycle(1'b1, 1'b1, 8'hE1, 1'b0, "lone_e1");
        check("lone_e1/verified0", 32'(verified), 32'd0);
        idle(BYTE_TIMEOUT + 5, "lone_e1_timeout");

        // Lockout is not retained across reset.
        send4(32'h11111111, "lk_a");
        send4(32'h22222222, "lk_b");
        send4(32'h33333333, "lk_c");
        mid_clock_reset("mid_lockout_reset");
        check("mid_lockout_reset/locked_out0", 32'(locked_out), 32'd0);
        idle(2, "post_reset_idle");

        // clear beats key_valid: the B6 is dropped, so the rest cannot verify.
        cycle(1'b1, 1'b1, 8'hB6, 1'b1, "clear_vs_byte");
        cycle(1'b1, 1'b1, 8'h3A, 1'b0, "cvb_b1");
        cycle(1'b1, 1'b1, 8'h5C, 1'b0, "cvb_b2");
        cycle(1'b1, 1'b1, 8'hE1, 1'b0, "cvb_b3");
        check("clear_vs_byte/no_verify", 32'(verified), 32'd0);
        cycle(1'b1, 1'b0, 8'h00, 1'b1, "cvb_abort");

        // Randomized traffic, biased towards correct bytes so sequences succeed.
        for (int n = 0; n < 4000; n++) begin
            logic       e, kv, c;
            logic [7:0] b;
            e  = ($urandom_range(9, 0) != 0);
            kv = ($urandom_range(2, 0) == 0);
            c  = ($urandom_range(39, 0) == 0);
            if ($urandom_range(1, 0) == 1 && m_bytes.size() < 4)
                b = key_at(m_bytes.size());
            else
                b = 8'($urandom);
            cycle(e, kv, b, c, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sentinel_auth_sequencer.md
SENTINEL_AUTH_SEQUENCER -- requirements
Module: sentinel_auth_sequencer

Interface
REQ-001 Parameter KEY, default 32'hB63A5CE1, four-byte authorization sequence; byte 0 = KEY[31:24], byte 3 = KEY[7:0].
REQ-002 Parameter MAX_FAIL, default 3, failed attempts that trigger lockout (range 1-7).
REQ-003 Parameter LOCKOUT_CYCLES, default 1024, lockout duration in enabled cycles (range 1-65535).
REQ-004 Parameter BYTE_TIMEOUT, default 255, maximum enabled cycles between bytes of one attempt (range 1-255).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 ena  input  1  global enable; when low, all state, counters and outputs hold.
REQ-008 key_byte  input  8  candidate key byte.
REQ-009 key_valid  input  1  single-cycle strobe qualifying key_byte.
REQ-010 clear  input  1  relock request; exits VERIFIED.
REQ-011 status  output  8  seven-segment code: LOCKED 8'hC7, VERIFIED 8'hC1, LOCKOUT 8'h8E.
REQ-012 verified  output  1  high only in VERIFIED.
REQ-013 locked_out  output  1  high only in LOCKOUT.
REQ-014 fail_count  output  3  failed attempts since last success or lockout expiry.

Function
REQ-015 FSM states SHALL be IDLE, COLLECT, VERIFIED, LOCKOUT; all transitions require ena=1.
REQ-016 Accepted byte = key_valid=1 and ena=1 in IDLE or COLLECT; key_valid ignored in VERIFIED and LOCKOUT.
REQ-017 IDLE: accepted byte -> COLLECT, byte index 1, mismatch flag = (key_byte != KEY byte 0).
REQ-018 COLLECT: each accepted byte compared against KEY byte at current index; mismatch flag ORs in; index increments.
REQ-019 Comparison SHALL never abort early: exactly four bytes collected per attempt regardless of mismatches.
REQ-020 On fourth accepted byte with final mismatch flag 0: next cycle state=VERIFIED, fail_count=0.
REQ-021 On fourth accepted byte with final mismatch flag 1: fail_count increments; if new value == MAX_FAIL -> LOCKOUT, else -> IDLE.
REQ-022 verified and status=8'hC1 SHALL assert the cycle after the fourth byte is sampled (latency 1).
REQ-023 Inter-byte timer reloads on each accepted byte; in COLLECT, BYTE_TIMEOUT enabled cycles without key_valid -> failed attempt per REQ-021.
REQ-024 VERIFIED: held until clear=1 with ena=1 -> IDLE, index and mismatch flag cleared.
REQ-025 clear in IDLE or COLLECT SHALL abort any partial attempt -> IDLE without incrementing fail_count; clear ignored in LOCKOUT.
REQ-026 clear and key_valid in same cycle: clear wins, byte discarded.
REQ-027 LOCKOUT entry loads 16-bit timer with LOCKOUT_CYCLES; decrements each enabled cycle; at 0 -> IDLE and fail_count=0.
REQ-028 fail_count SHALL saturate at MAX_FAIL; no wrap.
REQ-029 status SHALL be 8'hC7 in IDLE and COLLECT, 8'hC1 in VERIFIED, 8'h8E in LOCKOUT, registered from state.
REQ-030 Fourth byte and timeout expiring in same cycle: byte accepted, timeout ignored.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, status=8'hC7, verified=0, locked_out=0, fail_count=0, index/flag/timers=0.
REQ-032 Reset mid-attempt or mid-lockout SHALL discard all progress; lockout NOT retained across reset.
REQ-033 First edge after rst_n rises SHALL be a normal IDLE cycle.

Verification
REQ-034 Reset 5 cycles, bytes B6,3A,5C,E1 on consecutive cycles -> verified=1, status=C1 one cycle after E1; clear -> status=C7.
REQ-035 Bytes B6,00,5C,E1 -> no early abort, after fourth byte status=C7, fail_count=1; repeat twice more -> locked_out=1, status=8E.
REQ-036 In LOCKOUT, send correct sequence -> ignored; after 1024 enabled cycles -> IDLE, fail_count=0; ena low for 10 cycles extends lockout by 10.
REQ-037 B6,3A then 255 idle cycles -> fail_count=1, IDLE; next correct full sequence -> VERIFIED.
REQ-038 B6,3A,5C then rst_n low for one cycle mid-clock -> outputs reset immediately; E1 alone -> COLLECT, no VERIFIED.
REQ-039 clear with key_valid=1 (byte B6) in IDLE -> stays IDLE, index 0; formal: verified=1 implies last four accepted bytes equal KEY.
